// File: rtl/nn_layer_seq.sv
// nn_layer_seq
//   Time-multiplexed fully-connected neuron layer. A frame of N_IN signed Q8.8
//   samples is buffered, then each of the N_OUT neurons is evaluated in turn on
//   one shared multiply-accumulate unit. The result is either the saturated
//   Q16.16 sum or a piecewise-linear sigmoid of it. Weights and biases live in
//   an internal RAM. They can only be written while idle, and they are never
//   reset.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/valid/ready    Q8.8 input sample stream
//   act_en                 1 = sigmoid, 0 = linear; sampled on the first sample of a frame
//   w_we/w_addr/w_data     weight/bias write port (address j*(N_IN+1)+i, i=N_IN is the bias)
//   out_data/idx/last      Q16.16 result, neuron index, last-neuron flag
//   out_valid/ready        output handshake
//   busy                   high whenever a frame is in progress
//
// state  | meaning
// IDLE   | waiting for the first sample; weight writes allowed
// LOAD   | buffering samples 1..N_IN-1
// MAC    | accumulating N_IN products for neuron j
// ACT    | saturate / activate, register the result
// OUT    | holding the result until it is accepted
module nn_layer_seq #(
  parameter  int N_IN  = 22,
  parameter  int N_OUT = 4,
  parameter  int ACC_W = 40,
  localparam int AW    = $clog2(N_OUT * (N_IN + 1)),
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             act_en,
  input  logic             w_we,
  input  logic [AW-1:0]    w_addr,
  input  logic [15:0]      w_data,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int STRIDE = N_IN + 1;
  localparam int NW     = N_OUT * STRIDE;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_ACT, S_OUT} state_t;

  state_t                   state_q;
  logic signed [15:0]       x_q [N_IN];
  logic signed [15:0]       w_q [NW];
  logic [IW-1:0]            in_cnt_q;
  logic [IW-1:0]            i_q;
  logic [IDX_W-1:0]         j_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     act_q;
  logic [31:0]              out_data_q;
  logic [IDX_W-1:0]         out_idx_q;
  logic                     out_last_q;
  logic                     out_valid_q;

  logic                     in_xfer;
  logic [AW-1:0]            mac_addr;
  logic [AW-1:0]            bias_addr;
  logic [IDX_W-1:0]         bias_j;
  logic signed [15:0]       bias_w;
  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_bias;
  logic [31:0]              s, a, y, act_res;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign in_xfer  = in_valid && in_ready;

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  assign mac_addr = AW'(int'(j_q) * STRIDE + int'(i_q));

  // Bias of the neuron about to enter MAC: neuron 0 from IDLE/LOAD, j+1 from OUT.
  assign bias_j    = (state_q == S_OUT) ? j_q + IDX_W'(1) : '0;
  assign bias_addr = AW'(int'(bias_j) * STRIDE + N_IN);
  // With N_IN=1 the frame starts MAC straight from IDLE; forward a same-cycle bias write.
  assign bias_w    = (state_q == S_IDLE && w_we && w_addr == bias_addr) ? w_data : w_q[bias_addr];
  assign acc_bias  = {{(ACC_W-24){bias_w[15]}}, bias_w, 8'h00};

  assign prod     = x_q[i_q] * w_q[mac_addr];
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

  always_comb begin
    if (acc_q[ACC_W-1:31] == '0 || acc_q[ACC_W-1:31] == '1) s = acc_q[31:0];
    else if (acc_q[ACC_W-1])                                 s = 32'h8000_0000;
    else                                                     s = 32'h7FFF_FFFF;

    if (!s[31])                   a = s;
    else if (s == 32'h8000_0000) a = 32'h7FFF_FFFF;
    else                          a = -s;

    if (a >= 32'h0005_0000)      y = 32'h0001_0000;
    else if (a >= 32'h0002_6000) y = (a >> 5) + 32'h0000_D800;
    else if (a >= 32'h0001_0000) y = (a >> 3) + 32'h0000_A000;
    else                         y = (a >> 2) + 32'h0000_8000;

    if (!act_q)      act_res = s;
    else if (!s[31]) act_res = y;
    else             act_res = 32'h0001_0000 - y;
  end

  // Sample buffer and weight RAM carry no reset: weights persist across resets.
  always_ff @(posedge clk) begin
    if (in_xfer) x_q[in_cnt_q] <= in_data;
    if (w_we && state_q == S_IDLE) w_q[w_addr] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      act_q       <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_xfer) begin
            act_q <= act_en;
            if (N_IN == 1) begin
              state_q  <= S_MAC;
              in_cnt_q <= '0;
              i_q      <= '0;
              j_q      <= '0;
              acc_q    <= acc_bias;
            end else begin
              state_q  <= S_LOAD;
              in_cnt_q <= IW'(1);
            end
          end
        end
        S_LOAD: begin
          if (in_xfer) begin
            if (in_cnt_q == IW'(N_IN - 1)) begin
              state_q  <= S_MAC;
              in_cnt_q <= '0;
              i_q      <= '0;
              j_q      <= '0;
              acc_q    <= acc_bias;
            end else begin
              in_cnt_q <= in_cnt_q + IW'(1);
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_q + prod_ext;
          if (i_q == IW'(N_IN - 1)) begin
            state_q <= S_ACT;
            i_q     <= '0;
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        S_ACT: begin
          out_data_q  <= act_res;
          out_idx_q   <= j_q;
          out_last_q  <= (j_q == IDX_W'(N_OUT - 1));
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (j_q == IDX_W'(N_OUT - 1)) begin
              state_q <= S_IDLE;
            end else begin
              j_q     <= j_q + IDX_W'(1);
              acc_q   <= acc_bias;
              state_q <= S_MAC;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// tb_nn_layer_seq
//   Self-checking bench for nn_layer_seq. Expected outputs come from an
//   arithmetic reference of the layer (wide integer dot product, clamp,
//   piecewise sigmoid) over weight and input arrays held in the bench.
module tb_nn_layer_seq;
  localparam int N_IN  = 22;
  localparam int N_OUT = 4;
  localparam int ACC_W = 40;
  localparam int AW    = $clog2(N_OUT * (N_IN + 1));
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic             act_en;
  logic             w_we;
  logic [AW-1:0]    w_addr;
  logic [15:0]      w_data;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int W [N_OUT][N_IN+1];
  int xv [N_IN];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_last  = 0;

  nn_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .act_en(act_en),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rnd(int r);
    return int'($urandom_range(0, 2 * r)) - r;
  endfunction

  function automatic logic [31:0] model(int j, bit act);
    longint acc, s, a, y, r;
    acc = longint'(W[j][N_IN]) * 256;
    for (int i = 0; i < N_IN; i++) acc += longint'(xv[i]) * longint'(W[j][i]);
    s = (acc > SMAX) ? SMAX : (acc < SMIN) ? SMIN : acc;
    if (!act) return s[31:0];
    a = (s < 0) ? -s : s;
    if (a > SMAX) a = SMAX;
    if (a >= 327680)      y = 65536;
    else if (a >= 155648) y = a / 32 + 55296;
    else if (a >= 65536)  y = a / 8 + 40960;
    else                  y = a / 4 + 32768;
    r = (s >= 0) ? y : 65536 - y;
    return r[31:0];
  endfunction

  task automatic load_weights();
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i <= N_IN; i++) begin
        w_we   = 1'b1;
        w_addr = AW'(j * (N_IN + 1) + i);
        w_data = 16'(W[j][i]);
        @(posedge clk); #1;
      end
    w_we = 1'b0;
  endtask

  task automatic fill(int xval, int wval, int bval);
    for (int i = 0; i < N_IN; i++) xv[i] = xval;
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) W[j][i] = wval;
      W[j][N_IN] = bval;
    end
  endtask

  task automatic randomize_all(int rx, int rw);
    for (int i = 0; i < N_IN; i++) xv[i] = rnd(rx);
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i <= N_IN; i++) W[j][i] = rnd(rw);
  endtask

  // wmode 1: weight write during LOAD (must be ignored)
  // wmode 2: bias write in the same IDLE cycle as the first sample (must apply)
  task automatic send_frame(input bit act, input int wmode);
    int v;
    for (int k = 0; k < N_IN; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(xv[k]);
      act_en   = (k == 0) ? act : !act;
      if (wmode == 2 && k == 0) begin
        v = rnd(255);
        W[N_OUT-1][N_IN] = v;
        w_we   = 1'b1;
        w_addr = AW'((N_OUT - 1) * (N_IN + 1) + N_IN);
        w_data = 16'(v);
      end
      if (wmode == 1 && k == 3) begin
        w_we   = 1'b1;
        w_addr = '0;
        w_data = 16'(W[0][0]) ^ 16'h5A5A;
      end
      @(posedge clk); #1;
      w_we = 1'b0;
    end
    in_valid = 1'b0;
    t_last   = cyc;
  endtask

  task automatic collect(input bit act, input int n_exp, input int stall_idx);
    int t_ref, n;
    logic [31:0] e;
    t_ref = t_last;
    for (int j = 0; j < n_exp; j++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (out_valid !== 1'b1 && n < 200);
      if (out_valid !== 1'b1) begin
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
        return;
      end
      e = model(j, act);
      chk($sformatf("latency%0d", j), cyc - t_ref, N_IN + 1);
      chk($sformatf("data%0d", j), out_data, e);
      chk($sformatf("idx%0d", j), 32'(out_idx), j);
      chk($sformatf("last%0d", j), 32'(out_last), (j == N_OUT - 1) ? 1 : 0);
      if (j == stall_idx) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", out_data, e);
          chk("stall_idx", 32'(out_idx), j);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      t_ref = cyc;
    end
    if (n_exp == N_OUT) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({pfx, "_out_data"}, out_data, 32'd0);
    chk({pfx, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({pfx, "_out_last"}, 32'(out_last), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int st;
    bit act;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; act_en = 1'b0;
    w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero weights, sigmoid -> 0.5 everywhere
    fill(0, 0, 0);
    for (int i = 0; i < N_IN; i++) xv[i] = rnd(32767);
    load_weights();
    send_frame(1'b1, 0);
    collect(1'b1, N_OUT, -1);

    // all ones: sigmoid saturates to 1.0, linear sum = 22.0
    fill(16'h0100, 16'h0100, 0);
    load_weights();
    send_frame(1'b1, 0);
    collect(1'b1, N_OUT, -1);
    send_frame(1'b0, 0);
    collect(1'b0, N_OUT, -1);

    // single negative weight on neuron 0, bias only on neuron 1
    fill(16'h0100, 0, 0);
    W[0][0]    = -128;
    W[1][N_IN] = 16'h0180;
    load_weights();
    send_frame(1'b1, 0);
    collect(1'b1, N_OUT, -1);

    // positive and negative saturation
    fill(32767, 32767, 0);
    load_weights();
    send_frame(1'b0, 0);
    collect(1'b0, N_OUT, -1);
    fill(32767, -32768, 0);
    load_weights();
    send_frame(1'b0, 0);
    collect(1'b0, N_OUT, -1);

    // backpressure on neuron 1
    randomize_all(255, 255);
    load_weights();
    send_frame(1'b1, 0);
    collect(1'b1, N_OUT, 1);

    // random frames over several magnitude ranges
    for (int f = 0; f < 6; f++) begin
      case (f % 3)
        0:       randomize_all(32767, 32767);
        1:       randomize_all(400, 400);
        default: randomize_all(96, 96);
      endcase
      load_weights();
      act = 1'($urandom_range(0, 1));
      st  = int'($urandom_range(0, N_OUT));
      send_frame(act, (f == 2 || f == 4) ? 2 : 0);
      collect(act, N_OUT, st);
    end

    // reset in the middle of neuron 2, then a frame with an ignored LOAD write
    randomize_all(300, 300);
    load_weights();
    send_frame(1'b1, 0);
    collect(1'b1, 2, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_mac_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(1'b1, 1);
    collect(1'b1, N_OUT, -1);
    send_frame(1'b0, 0);
    collect(1'b0, N_OUT, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
